rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NUM_RST, default 4, number of sequenced reset outputs (range 1..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, ref_clk_i cycles between successive releases (range 1..1024).
REQ-003 SHALL have parameter HOLD_CYCLES, default 8, minimum cycles all outputs stay asserted after a request (range 1..1024).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, flops in the reset-release synchronizer (range 2..4).
REQ-005 SHALL have port ref_clk_i  input  1  reference clock; the only clock.
REQ-006 SHALL have port arst_ni  input  1  asynchronous active-low reset; driven by the upstream asynchronous reset generator output.
REQ-007 SHALL have port rst_req_i  input  1  level reset request, synchronous to ref_clk_i.
REQ-008 SHALL have port rst_ack_o  output  1  high while a request is being serviced (HOLD state).
REQ-009 SHALL have port rst_n_o  output  NUM_RST  active-low domain resets; bit 0 released first.
REQ-010 SHALL have port seq_done_o  output  1  high when all rst_n_o bits are released.

Function
REQ-011 SHALL implement states SYNC, RELEASE, DONE, HOLD.
REQ-012 SHALL treat arst_ni deassertion as effective only after SYNC_STAGES rising edges of ref_clk_i; SYNC exits to RELEASE on the first edge with the synchronized reset high.
REQ-013 SHALL, in RELEASE, run a gap counter 0..GAP_CYCLES-1; at terminal count release the next bit (rst_n_o[k] goes 1), clear the counter, and increment the index.
REQ-014 SHALL release rst_n_o[k] at rising edge SYNC_STAGES + (k+1)*GAP_CYCLES after the first edge following arst_ni deassertion, under the default parameters.
REQ-015 SHALL enter DONE and set seq_done_o on the same edge that releases rst_n_o[NUM_RST-1].
REQ-016 SHALL release rst_n_o bits monotonically: once high, a bit falls only by arst_ni or entry to HOLD.
REQ-017 SHALL, on rst_req_i sampled high in RELEASE or DONE, clear all rst_n_o bits and seq_done_o, and set rst_ack_o, on the next edge (enter HOLD).
REQ-018 SHALL remain in HOLD until at least HOLD_CYCLES cycles have elapsed and rst_req_i is sampled low; it then clears rst_ack_o, resets the counter and index, and enters RELEASE.
REQ-019 SHALL ignore rst_req_i in SYNC.
REQ-020 SHALL give rst_req_i priority over a release due in the same cycle: no bit is released on that edge.
REQ-021 SHALL size the counters as $clog2 of the larger of GAP_CYCLES and HOLD_CYCLES, plus 1, with no wrap-around beyond the terminal count.
REQ-022 SHALL drive all outputs directly from flops (no combinational paths from inputs).

Reset
REQ-023 SHALL, while arst_ni is low, force rst_n_o = 0, seq_done_o = 0, rst_ack_o = 0, state = SYNC, and counters/index = 0, asynchronously and independently of ref_clk_i.
REQ-024 SHALL abort any sequence or HOLD on arst_ni assertion mid-operation and restart from SYNC.

Structure
REQ-025 SHALL place the state enum type (rst_seq_state_e) and parameter range limits in shared package crg_pkg.
REQ-026 SHALL instantiate one sub-module, rst_sync: a SYNC_STAGES-deep asynchronous-assert, synchronous-deassert synchronizer for arst_ni.
REQ-027 SHALL keep the sequencer FSM, gap/hold counter, and index register in rst_seq itself.

Verification (NUM_RST=4, GAP_CYCLES=16, HOLD_CYCLES=8, SYNC_STAGES=2)
REQ-028 SHALL cover power-up: arst_ni rises, then rst_n_o goes 0001, 0011, 0111, 1111 at edges 18, 34, 50, 66, with seq_done_o=1 at edge 66.
REQ-029 SHALL cover a request in DONE: rst_req_i held high for 3 cycles, then rst_n_o=0000 and rst_ack_o=1 on the next edge; HOLD lasts 8 cycles; bit 0 is re-released 16 cycles after HOLD exits.
REQ-030 SHALL cover a long request: rst_req_i held high for 40 cycles, with rst_ack_o high until the edge after rst_req_i is sampled low.
REQ-031 SHALL cover a request mid-RELEASE (rst_n_o=0011): all bits drop next edge, and the re-sequence starts from bit 0.
REQ-032 SHALL cover arst_ni asserted mid-HOLD and mid-RELEASE: all outputs go 0 immediately (no clock edge), and a full power-up sequence follows deassertion.
REQ-033 SHALL cover rst_req_i high on the same edge bit 2 is due: bit 2 is not released, and HOLD is entered.

Source files
------------

// File: rtl/crg_pkg.sv
// Shared clock/reset-generation types and parameter limits.
// Used by the reset sequencer and its synchronizer.
package crg_pkg;

    typedef enum logic [1:0] {
        StSync,
        StRelease,
        StDone,
        StHold
    } rst_seq_state_e;

    localparam int unsigned NumRstMin     = 1;
    localparam int unsigned NumRstMax     = 16;
    localparam int unsigned GapCyclesMin  = 1;
    localparam int unsigned GapCyclesMax  = 1024;
    localparam int unsigned HoldCyclesMin = 1;
    localparam int unsigned HoldCyclesMax = 1024;
    localparam int unsigned SyncStagesMin = 2;
    localparam int unsigned SyncStagesMax = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_ni,
    output logic rst_no
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases NUM_RST domain resets one by one, GAP_CYCLES apart,
// and re-sequences after a held software reset request.
module rst_seq
    import crg_pkg::*;
#(
    parameter int unsigned NUM_RST     = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               ref_clk_i,
    input  logic               arst_ni,
    input  logic               rst_req_i,
    output logic               rst_ack_o,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               seq_done_o
);

    localparam int unsigned CntW = $clog2(max_u(GAP_CYCLES, HOLD_CYCLES)) + 1;
    localparam int unsigned IdxW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [CntW-1:0] GapTerm  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] HoldTerm = CntW'(HOLD_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_RST - 1);

    if (NUM_RST < NumRstMin || NUM_RST > NumRstMax ||
        GAP_CYCLES < GapCyclesMin || GAP_CYCLES > GapCyclesMax ||
        HOLD_CYCLES < HoldCyclesMin || HOLD_CYCLES > HoldCyclesMax ||
        SYNC_STAGES < SyncStagesMin || SYNC_STAGES > SyncStagesMax) begin : g_param_check
        $error("rst_seq: parameter out of range");
    end

    logic sync_rst_n;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i   (ref_clk_i),
        .arst_ni (arst_ni),
        .rst_no  (sync_rst_n)
    );

    rst_seq_state_e     state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NUM_RST-1:0] rst_n_q, rst_n_d;
    logic               ack_q, ack_d;
    logic               done_q, done_d;

    always_ff @(posedge ref_clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= StSync;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        ack_d   = ack_q;
        done_d  = done_q;

        unique case (state_q)
            StSync: begin
                // The exit edge already counts as the first gap cycle of bit 0.
                if (sync_rst_n) begin
                    state_d = StRelease;
                    cnt_d   = CntW'(1);
                end
            end
            StRelease: begin
                if (rst_req_i) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                    ack_d   = 1'b1;
                    done_d  = 1'b0;
                end else if (cnt_q >= GapTerm) begin
                    rst_n_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (rst_req_i) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                    ack_d   = 1'b1;
                    done_d  = 1'b0;
                end
            end
            StHold: begin
                // Counter saturates at the hold terminal count while the request persists.
                if (cnt_q >= HoldTerm) begin
                    if (!rst_req_i) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                        idx_d   = '0;
                        ack_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StSync;
        endcase
    end

    assign rst_n_o    = rst_n_q;
    assign rst_ack_o  = ack_q;
    assign seq_done_o = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected output changes with their
// cycle numbers; a monitor compares every observed output change against the queue.
module tb_rst_seq;

    logic       ref_clk;
    logic       arst_n;
    logic       rst_req;
    logic       rst_ack;
    logic [3:0] rst_n;
    logic       seq_done;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rst_n;
        logic       ack;
        logic       done;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    rst_seq #(
        .NUM_RST     (4),
        .GAP_CYCLES  (16),
        .HOLD_CYCLES (8),
        .SYNC_STAGES (2)
    ) dut (
        .ref_clk_i  (ref_clk),
        .arst_ni    (arst_n),
        .rst_req_i  (rst_req),
        .rst_ack_o  (rst_ack),
        .rst_n_o    (rst_n),
        .seq_done_o (seq_done)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge ref_clk);
        #2;
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic a, input logic d,
                        input string name);
        exp_t e;
        e.cyc   = c;
        e.rst_n = r;
        e.ack   = a;
        e.done  = d;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Full power-up release from arst_n deassertion at cycle b.
    task automatic push_powerup(input int b, input string tag);
        push(b + 18, 4'b0001, 1'b0, 1'b0, {tag, "_bit0"});
        push(b + 34, 4'b0011, 1'b0, 1'b0, {tag, "_bit1"});
        push(b + 50, 4'b0111, 1'b0, 1'b0, {tag, "_bit2"});
        push(b + 66, 4'b1111, 1'b0, 1'b1, {tag, "_bit3_done"});
    endtask

    // Re-sequence after HOLD exits at cycle x.
    task automatic push_resequence(input int x, input string tag);
        push(x + 16, 4'b0001, 1'b0, 1'b0, {tag, "_bit0"});
        push(x + 32, 4'b0011, 1'b0, 1'b0, {tag, "_bit1"});
        push(x + 48, 4'b0111, 1'b0, 1'b0, {tag, "_bit2"});
        push(x + 64, 4'b1111, 1'b0, 1'b1, {tag, "_bit3_done"});
    endtask

    initial begin : monitor
        logic [5:0] prev;
        logic [5:0] cur;
        logic [5:0] want;
        exp_t       e;
        prev = 6'b0;
        forever begin
            @(negedge ref_clk or negedge arst_n);
            #1;
            cur = {rst_n, rst_ack, seq_done};
            if (cur !== prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got rst_n/ack/done=%b at cycle %0d, required no change",
                             cur, cyc);
                end else begin
                    e    = exp_q.pop_front();
                    want = {e.rst_n, e.ack, e.done};
                    if (cur !== want || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL %s: got rst_n/ack/done=%b at cycle %0d, required %b at cycle %0d",
                                 e.name, cur, cyc, want, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        int c;
        int b;
        arst_n  = 1'b0;
        rst_req = 1'b0;
        step(3);

        n_tests++;
        if ({rst_n, rst_ack, seq_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rst_n/ack/done=%b, required 000000",
                     {rst_n, rst_ack, seq_done});
        end

        // Power-up; rst_req_i is ignored while in SYNC.
        b = cyc;
        arst_n  = 1'b1;
        rst_req = 1'b1;
        push_powerup(b, "powerup");
        step(1);
        rst_req = 1'b0;
        step(69);

        // Request in DONE, held 3 cycles.
        c = cyc;
        push(c + 1, 4'b0000, 1'b1, 1'b0, "done_req_hold");
        push(c + 9, 4'b0000, 1'b0, 1'b0, "done_req_exit");
        push_resequence(c + 9, "done_req");
        rst_req = 1'b1;
        step(3);
        rst_req = 1'b0;
        step(77);

        // Long request: 40 cycles.
        c = cyc;
        push(c + 1,  4'b0000, 1'b1, 1'b0, "long_req_hold");
        push(c + 41, 4'b0000, 1'b0, 1'b0, "long_req_exit");
        push_resequence(c + 41, "long_req");
        rst_req = 1'b1;
        step(40);
        rst_req = 1'b0;
        step(70);

        // Request mid-RELEASE at 0011.
        c = cyc;
        push(c + 1,  4'b0000, 1'b1, 1'b0, "pre_mid_hold");
        push(c + 9,  4'b0000, 1'b0, 1'b0, "pre_mid_exit");
        push(c + 25, 4'b0001, 1'b0, 1'b0, "pre_mid_bit0");
        push(c + 41, 4'b0011, 1'b0, 1'b0, "pre_mid_bit1");
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(44);
        c = cyc;
        push(c + 1, 4'b0000, 1'b1, 1'b0, "mid_rel_hold");
        push(c + 9, 4'b0000, 1'b0, 1'b0, "mid_rel_exit");
        push_resequence(c + 9, "mid_rel");
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(79);

        // Request on the same edge bit 2 is due.
        c = cyc;
        push(c + 1,  4'b0000, 1'b1, 1'b0, "prio_pre_hold");
        push(c + 9,  4'b0000, 1'b0, 1'b0, "prio_pre_exit");
        push(c + 25, 4'b0001, 1'b0, 1'b0, "prio_bit0");
        push(c + 41, 4'b0011, 1'b0, 1'b0, "prio_bit1");
        push(c + 57, 4'b0000, 1'b1, 1'b0, "prio_hold_not_bit2");
        push(c + 65, 4'b0000, 1'b0, 1'b0, "prio_exit");
        push_resequence(c + 65, "prio");
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(55);
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(78);

        // arst_n asserted mid-HOLD: outputs clear without a clock edge.
        c = cyc;
        push(c + 1, 4'b0000, 1'b1, 1'b0, "arst_hold_ack");
        rst_req = 1'b1;
        step(3);
        push(cyc, 4'b0000, 1'b0, 1'b0, "arst_hold_clear");
        arst_n = 1'b0;
        rst_req = 1'b0;
        step(3);

        // Power-up, then arst_n asserted mid-RELEASE at 0011.
        b = cyc;
        push(b + 18, 4'b0001, 1'b0, 1'b0, "arst_rel_bit0");
        push(b + 34, 4'b0011, 1'b0, 1'b0, "arst_rel_bit1");
        arst_n = 1'b1;
        step(40);
        push(cyc, 4'b0000, 1'b0, 1'b0, "arst_rel_clear");
        arst_n = 1'b0;
        step(3);

        b = cyc;
        push_powerup(b, "repowerup");
        arst_n = 1'b1;
        step(72);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d expected changes never seen, required 0",
                     exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
